// File: rtl/sat_accum_pkg.sv
// Shared types and helpers for the multi-channel saturating accumulator.
// Arithmetic helpers work on a fixed-width word so any N up to MAX_N can use them.
package sat_accum_pkg;

    localparam int MAX_N = 32;

    typedef logic [MAX_N-1:0] word_t;

    typedef struct packed {
        logic  ov;
        logic  uv;
        word_t result;
    } add_res_t;

    // Largest positive n-bit value, sign-extended into a word.
    function automatic word_t max_val(input int n);
        word_t r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n - 1) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Most negative n-bit value, sign-extended into a word.
    function automatic word_t min_val(input int n);
        word_t r;
        r = '1;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n - 1) r[i] = 1'b0;
        end
        return r;
    endfunction

    // a and b hold sign-extended n-bit values; flags are judged at n+1 bits.
    function automatic add_res_t sat_add(input word_t a, input word_t b,
                                         input logic sat, input int n);
        logic [MAX_N:0]           ext;
        logic [$clog2(MAX_N+1)-1:0] hi;
        logic [$clog2(MAX_N+1)-1:0] lo;
        add_res_t                 r;
        ext = {a[MAX_N-1], a} + {b[MAX_N-1], b};
        hi  = ($clog2(MAX_N+1))'(n);
        lo  = ($clog2(MAX_N+1))'(n - 1);
        r.ov = !ext[hi] && ext[lo];
        r.uv = ext[hi] && !ext[lo];
        if (sat && r.ov)      r.result = max_val(n);
        else if (sat && r.uv) r.result = min_val(n);
        else                  r.result = ext[MAX_N-1:0];
        return r;
    endfunction

endpackage

// File: rtl/sat_accum_add_core.sv
// Combinational N+1-bit signed add with overflow/underflow flags and optional clamp.
module sat_add_core
    import sat_accum_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sat,
    output logic         ov,
    output logic         uv,
    output logic [N-1:0] sum
);

    localparam word_t        MAX_W = max_val(N);
    localparam word_t        MIN_W = min_val(N);
    localparam logic [N-1:0] MAX_V = MAX_W[N-1:0];
    localparam logic [N-1:0] MIN_V = MIN_W[N-1:0];

    logic [N:0] ext;

    always_comb begin
        ext = {a[N-1], a} + {b[N-1], b};
        ov  = !ext[N] && ext[N-1];
        uv  = ext[N] && !ext[N-1];
        if (sat && ov)      sum = MAX_V;
        else if (sat && uv) sum = MIN_V;
        else                sum = ext[N-1:0];
    end

endmodule

// File: rtl/sat_accum.sv
// Multi-channel signed accumulator: per-channel sums, saturate/wrap per beat,
// sticky overflow flags, and a one-deep valid/ready output register.
module sat_accum
    import sat_accum_pkg::*;
#(
    parameter  int N      = 8,
    parameter  int NUM_CH = 4,
    localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_ch,
    input  logic [N-1:0]      in_data,
    input  logic              in_load,
    input  logic              sat_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_ch,
    output logic [N-1:0]      out_data,
    output logic              out_ov,
    output logic              out_uv,
    output logic [NUM_CH-1:0] sticky_ov,
    output logic [NUM_CH-1:0] sticky_uv,
    input  logic              flag_clr
);

    logic [N-1:0] acc [NUM_CH];

    logic [N-1:0] acc_cur;
    logic         ch_ok;
    logic         accept;
    logic         wr;
    logic         core_ov;
    logic         core_uv;
    logic [N-1:0] core_sum;
    logic [N-1:0] new_val;
    logic         new_ov;
    logic         new_uv;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Loop mux keeps out-of-range channel codes from indexing the array.
    always_comb begin
        acc_cur = '0;
        ch_ok   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_ch == CW'(i)) begin
                acc_cur = acc[i];
                ch_ok   = 1'b1;
            end
        end
    end

    assign wr = accept && ch_ok;

    sat_add_core #(.N(N)) u_core (
        .a   (acc_cur),
        .b   (in_data),
        .sat (sat_mode),
        .ov  (core_ov),
        .uv  (core_uv),
        .sum (core_sum)
    );

    always_comb begin
        new_val = in_load ? in_data : core_sum;
        new_ov  = !in_load && core_ov;
        new_uv  = !in_load && core_uv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr && in_ch == CW'(i)) acc[i] <= new_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_ov    <= 1'b0;
            out_uv    <= 1'b0;
        end else if (wr) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            out_data  <= new_val;
            out_ov    <= new_ov;
            out_uv    <= new_uv;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A set on the same cycle as flag_clr wins for that channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ov <= '0;
            sticky_uv <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                sticky_ov[i] <= (sticky_ov[i] && !flag_clr) ||
                                (wr && in_ch == CW'(i) && new_ov);
                sticky_uv[i] <= (sticky_uv[i] && !flag_clr) ||
                                (wr && in_ch == CW'(i) && new_uv);
            end
        end
    end

endmodule

// File: tb/tb_sat_accum.sv
// Directed bench for sat_accum (N=8, NUM_CH=4) with hand-computed expectations.
module tb_sat_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_ch;
    logic [7:0] in_data;
    logic       in_load;
    logic       sat_mode;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_ch;
    logic [7:0] out_data;
    logic       out_ov;
    logic       out_uv;
    logic [3:0] sticky_ov;
    logic [3:0] sticky_uv;
    logic       flag_clr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sat_accum #(.N(8), .NUM_CH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .in_load   (in_load),
        .sat_mode  (sat_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .out_ov    (out_ov),
        .out_uv    (out_uv),
        .sticky_ov (sticky_ov),
        .sticky_uv (sticky_uv),
        .flag_clr  (flag_clr)
    );

    // Presents one beat for exactly one rising edge; caller guarantees in_ready.
    task automatic send(input logic [1:0] ch, input logic [7:0] d,
                        input logic ld, input logic sat);
        @(negedge clk);
        in_ch    = ch;
        in_data  = d;
        in_load  = ld;
        sat_mode = sat;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_load  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %h want 00", out_data); end
        n_cmp++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL reset_out_ch got %0d want 0", out_ch); end
        n_cmp++; if ({out_ov, out_uv} !== 2'b00) begin n_err++; $display("FAIL reset_out_flags got %b want 00", {out_ov, out_uv}); end
        n_cmp++; if ({sticky_ov, sticky_uv} !== 8'h00) begin n_err++; $display("FAIL reset_sticky got %h want 00", {sticky_ov, sticky_uv}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_sat_ov();
        send(2'd0, 8'd100, 1'b1, 1'b1);
        n_cmp++; if (out_data !== 8'd100 || out_ov !== 1'b0) begin n_err++; $display("FAIL sat_load got %h ov %b want 64 ov 0", out_data, out_ov); end
        send(2'd0, 8'd50, 1'b0, 1'b1);
        n_cmp++; if (out_data !== 8'h7f) begin n_err++; $display("FAIL sat_ov_data got %h want 7f", out_data); end
        n_cmp++; if (out_ov !== 1'b1 || out_uv !== 1'b0) begin n_err++; $display("FAIL sat_ov_flags got ov %b uv %b want 1 0", out_ov, out_uv); end
        n_cmp++; if (sticky_ov !== 4'b0001) begin n_err++; $display("FAIL sat_ov_sticky got %b want 0001", sticky_ov); end
        n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd0) begin n_err++; $display("FAIL sat_ov_beat got v %b ch %0d want 1 0", out_valid, out_ch); end
    endtask

    task automatic test_wrap_ov();
        send(2'd0, 8'd100, 1'b1, 1'b0);
        send(2'd0, 8'd50, 1'b0, 1'b0);
        n_cmp++; if (out_data !== 8'h96) begin n_err++; $display("FAIL wrap_data got %h want 96", out_data); end
        n_cmp++; if (out_ov !== 1'b1) begin n_err++; $display("FAIL wrap_ov got %b want 1", out_ov); end
    endtask

    task automatic test_sat_uv();
        send(2'd1, 8'h9c, 1'b1, 1'b1);
        send(2'd1, 8'hce, 1'b0, 1'b1);
        n_cmp++; if (out_data !== 8'h80) begin n_err++; $display("FAIL sat_uv_data got %h want 80", out_data); end
        n_cmp++; if (out_uv !== 1'b1 || out_ov !== 1'b0) begin n_err++; $display("FAIL sat_uv_flags got ov %b uv %b want 0 1", out_ov, out_uv); end
        n_cmp++; if (sticky_uv !== 4'b0010) begin n_err++; $display("FAIL sat_uv_sticky got %b want 0010", sticky_uv); end
        n_cmp++; if (out_ch !== 2'd1) begin n_err++; $display("FAIL sat_uv_ch got %0d want 1", out_ch); end
        send(2'd0, 8'd0, 1'b0, 1'b1);
        n_cmp++; if (out_data !== 8'h96 || out_ov !== 1'b0) begin n_err++; $display("FAIL ch0_untouched got %h ov %b want 96 ov 0", out_data, out_ov); end
    endtask

    task automatic test_interleave();
        logic [7:0] e0;
        logic [7:0] e2;
        e0 = 8'd0;
        e2 = 8'd0;
        send(2'd0, 8'd0, 1'b1, 1'b1);
        send(2'd2, 8'd0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            e0 = e0 + 8'd1;
            e2 = e2 - 8'd1;
            send(2'd0, 8'h01, 1'b0, 1'b1);
            n_cmp++; if (out_ch !== 2'd0 || out_data !== e0) begin n_err++; $display("FAIL inter_ch0 step %0d got ch %0d %h want ch 0 %h", i, out_ch, out_data, e0); end
            send(2'd2, 8'hff, 1'b0, 1'b1);
            n_cmp++; if (out_ch !== 2'd2 || out_data !== e2) begin n_err++; $display("FAIL inter_ch2 step %0d got ch %0d %h want ch 2 %h", i, out_ch, out_data, e2); end
        end
        n_cmp++; if (out_data !== 8'hf6) begin n_err++; $display("FAIL inter_final_ch2 got %h want f6", out_data); end
        send(2'd0, 8'd0, 1'b0, 1'b1);
        n_cmp++; if (out_data !== 8'd10) begin n_err++; $display("FAIL inter_final_ch0 got %h want 0a", out_data); end
    endtask

    task automatic test_flag_clr();
        send(2'd3, 8'h7f, 1'b1, 1'b1);
        flag_clr = 1'b1;
        send(2'd3, 8'h01, 1'b0, 1'b1);
        flag_clr = 1'b0;
        n_cmp++; if (out_data !== 8'h7f || out_ov !== 1'b1) begin n_err++; $display("FAIL clr_beat got %h ov %b want 7f ov 1", out_data, out_ov); end
        n_cmp++; if (sticky_ov !== 4'b1000) begin n_err++; $display("FAIL clr_sticky_ov got %b want 1000", sticky_ov); end
        n_cmp++; if (sticky_uv !== 4'b0000) begin n_err++; $display("FAIL clr_sticky_uv got %b want 0000", sticky_uv); end
    endtask

    task automatic test_back_to_back();
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        send(2'd1, 8'd5, 1'b1, 1'b1);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'd5) begin n_err++; $display("FAIL bp_first got v %b %h want 1 05", out_valid, out_data); end
        @(negedge clk);
        in_ch    = 2'd1;
        in_data  = 8'd3;
        in_load  = 1'b0;
        sat_mode = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cycle %0d got %b want 0", k, in_ready); end
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'd5 || out_ch !== 2'd1 || out_ov !== 1'b0) begin n_err++; $display("FAIL bp_hold cycle %0d got v %b %h ch %0d want 1 05 ch 1", k, out_valid, out_data, out_ch); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'd8) begin n_err++; $display("FAIL bp_next_beat got v %b %h want 1 08", out_valid, out_data); end
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup got %b want 0", out_valid); end
        send(2'd1, 8'd0, 1'b0, 1'b1);
        n_cmp++; if (out_data !== 8'd8) begin n_err++; $display("FAIL bp_acc got %h want 08", out_data); end
    endtask

    task automatic test_reset_mid();
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        send(2'd2, 8'd7, 1'b1, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rm_pending got %b want 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'd0) begin n_err++; $display("FAIL rm_out got v %b %h want 0 00", out_valid, out_data); end
        n_cmp++; if ({sticky_ov, sticky_uv, out_ov, out_uv} !== 10'd0) begin n_err++; $display("FAIL rm_flags got %b want 0", {sticky_ov, sticky_uv, out_ov, out_uv}); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(2'd0, 8'd5, 1'b0, 1'b1);
        n_cmp++; if (out_data !== 8'd5 || out_ov !== 1'b0) begin n_err++; $display("FAIL rm_add got %h ov %b want 05 ov 0", out_data, out_ov); end
        send(2'd2, 8'd0, 1'b0, 1'b1);
        n_cmp++; if (out_data !== 8'd0) begin n_err++; $display("FAIL rm_ch2_cleared got %h want 00", out_data); end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_ch     = 2'd0;
        in_data   = 8'd0;
        in_load   = 1'b0;
        sat_mode  = 1'b0;
        out_ready = 1'b1;
        flag_clr  = 1'b0;
        test_reset();
        test_sat_ov();
        test_wrap_ov();
        test_sat_uv();
        test_interleave();
        test_flag_clr();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sat_accum.md
# sat_accum

Multi-channel signed accumulator with per-channel saturation and overflow reporting, built on the signed-add/clamp arithmetic of the ALU test datapath. Each accepted input sample is added to the running sum of one of `NUM_CH` channels, or loaded into it. The result is clamped to the N-bit signed range or wrapped, as selected. Updated sums leave through a one-deep registered output with valid/ready flow control, and it is placed between sample sources and downstream filter/statistics logic.

## Interface
- `N`, 8, sample and accumulator width (two's complement), N >= 2
- `NUM_CH`, 4, number of independent accumulators, NUM_CH >= 1
- `CW`, derived = max(1, $clog2(NUM_CH)), channel index width (localparam)

- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: input beat present
- `in_ready` out 1: block can accept the beat
- `in_ch` in CW: target channel
- `in_data` in N: signed sample
- `in_load` in 1: 1 = load `in_data` into the channel, 0 = add
- `sat_mode` in 1: 1 = saturate, 0 = wrap; sampled per beat
- `out_valid` out 1: result beat present
- `out_ready` in 1: consumer accepts result
- `out_ch` out CW: channel of the result
- `out_data` out N: new accumulator value
- `out_ov` / `out_uv` out 1: this beat overflowed / underflowed
- `sticky_ov` / `sticky_uv` out NUM_CH: per-channel sticky flags
- `flag_clr` in 1: clear all sticky flags

## Operation
- Accept occurs when `in_valid && in_ready`. Only accepted beats change state.
- Sum is computed at N+1 bits: ext = sign-extend(acc[in_ch]) + sign-extend(in_data).
  - ov = ext[N]==0 && ext[N-1]==1, meaning the sum exceeds +(2^(N-1)-1).
  - uv = ext[N]==1 && ext[N-1]==0, meaning the sum is below -2^(N-1).
- New value:
  - Load: `in_data`, with ov = uv = 0.
  - Saturate mode: ov gives 2^(N-1)-1, uv gives -2^(N-1), otherwise ext[N-1:0].
  - Wrap mode: ext[N-1:0]. ov/uv are still reported.
- On accept, the block writes the new value to acc[in_ch] and registers `out_ch`/`out_data`/`out_ov`/`out_uv`. It sets `out_valid`=1, and ORs ov/uv into `sticky_ov[in_ch]`/`sticky_uv[in_ch]`.
- `in_ch` >= NUM_CH: the beat is accepted and dropped. There is no state change and no output beat.
- Other channels are never disturbed.

## Timing
- Reset (async assert, sync release):
  - All accumulators = 0, `out_valid`=0, `out_ch`=0, `out_data`=0, `out_ov`=`out_uv`=0, sticky flags = 0.
  - `in_ready`=1 while `rst_n`=1 and the output is empty.
- Reset asserted mid-operation discards any pending output beat and all sums immediately.
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready`=1.
- `in_ready` = !out_valid || out_ready. This is combinational from `out_ready` and has no combinational path from `in_valid`.
- While `out_valid`=1 && `out_ready`=0, all out_* signals hold stable.
- Back-to-back beats to the same channel use the sum just written, with no hazard. The accumulator register is updated on the accept edge.
- `flag_clr` with a simultaneous set on a channel: the set wins for that channel, and all other channels clear.
- `sat_mode` and `in_load` matter only on the accept cycle.

## Structure
- Package `sat_accum_pkg`:
  - Function `sat_add(a, b, sat)`, returning {ov, uv, result}.
  - MAX/MIN value constants, derived from N via a parameterised function.
- One sub-module, `sat_add_core` (combinational N+1-bit add, flags, clamp), instantiated once.
- The top level holds the accumulator array, the output register and the handshake.

## Test plan
- Saturate, ch0: load 100, then add 50. Expect `out_data`=127, `out_ov`=1, `sticky_ov[0]`=1.
- Wrap, ch0: load 100, then add 50. Expect `out_data`=-106 (0x96) and `out_ov`=1.
- Saturate, ch1: load -100, then add -50. Expect -128, `out_uv`=1, `sticky_uv[1]`=1. Ch0 is unchanged.
- Interleave ch0/ch2 adds of +1 and -1 for 10 beats each. Expect final sums 10 and -10, with `out_ch` tracking each beat.
- Hold `out_ready`=0 with one beat pending:
  - Expect `in_ready`=0 and out_* stable for 5 cycles.
  - Release. Expect the next beat to be accepted in the same cycle and no beat lost or duplicated.
- Assert `rst_n` low mid-stream. Expect `out_valid`=0 and all flags 0 at once. After release, a 0 + 5 add gives 5.
